// File: rtl/grad_counter_array.sv
// Multi-channel gradient stall counter: per-channel zero-gradient run counters
// that fire a one-cycle stall pulse and latch a bit from a shared Galois LFSR.
module grad_counter_lane #(
  parameter int GRAD_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              mask,
  input  logic [GRAD_W-1:0] grad,
  input  logic [CNT_W-1:0]  thr,
  input  logic              lfsr_bit,
  output logic              fire,
  output logic              stall_flag,
  output logic              phase
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic             phase_q, phase_d;

  always_comb begin
    fire    = 1'b0;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (ena) begin
      if (mask || (grad != '0)) begin
        cnt_d = thr;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        fire    = 1'b1;
        cnt_d   = thr;
        phase_d = lfsr_bit;
      end
    end
    stall_d = fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= thr;
      stall_q <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      phase_q <= phase_d;
    end
  end

  assign stall_flag = stall_q;
  assign phase      = phase_q;
endmodule

module grad_counter_array #(
  parameter int N_CH   = 8,
  parameter int GRAD_W = 4,
  parameter int CNT_W  = 8,
  parameter int EVT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   grad_counter_ena,
  input  logic [N_CH*GRAD_W-1:0] self_grad,
  input  logic [CNT_W-1:0]       grad_count_T,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic [15:0]            lfsr_seed,
  output logic [N_CH-1:0]        stall_flag,
  output logic [N_CH-1:0]        random_self_phase,
  output logic                   any_stall,
  output logic [EVT_W-1:0]       stall_event_count
);
  localparam int PW = $clog2(N_CH + 1);
  localparam int SW = ((EVT_W > PW) ? EVT_W : PW) + 1;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [N_CH-1:0]  fire;
  logic             any_q, any_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    grad_counter_lane #(.GRAD_W(GRAD_W), .CNT_W(CNT_W)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .ena        (grad_counter_ena),
      .mask       (ch_mask[i]),
      .grad       (self_grad[i*GRAD_W +: GRAD_W]),
      .thr        (grad_count_T),
      .lfsr_bit   (lfsr_q[i % 16]),
      .fire       (fire[i]),
      .stall_flag (stall_flag[i]),
      .phase      (random_self_phase[i])
    );
  end

  always_comb begin
    // Right-shift Galois form of x^16+x^14+x^13+x^11+1; nonzero state stays nonzero.
    lfsr_d = lfsr_q;
    if (grad_counter_ena)
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + PW'(fire[i]);
    any_d = |fire;
    sum   = SW'(evt_q) + SW'(pop);
    evt_d = (sum > SW'({EVT_W{1'b1}})) ? {EVT_W{1'b1}} : sum[EVT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= (lfsr_seed == 16'h0) ? 16'hACE1 : lfsr_seed;
      any_q  <= 1'b0;
      evt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      any_q  <= any_d;
      evt_q  <= evt_d;
    end
  end

  assign any_stall         = any_q;
  assign stall_event_count = evt_q;
endmodule

// File: doc/grad_counter_array.md
Name: grad_counter_array

Overview:
- Multi-channel, parametrised successor to the single-channel gradient stall counter.
- Per channel, counts consecutive enabled cycles with zero self-gradient. When the count expires it fires a stall event and emits a pseudo-random phase bit to kick that channel out of a local minimum.
- Sits between the NL gradient stage and the phase-update logic of a spin/oscillator array.
- Adds a shared LFSR, per-channel masking, a one-cycle stall pulse and a saturating aggregate event counter.

Parameters:
- N_CH, 8, number of independent channels (1..64).
- GRAD_W, 4, width of each channel's self-gradient slice.
- CNT_W, 8, counter/threshold width.
- EVT_W, 16, width of aggregate stall event counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- grad_counter_ena  in  1  global enable.
- self_grad  in  N_CH*GRAD_W  packed gradients; channel i is bits [i*GRAD_W +: GRAD_W].
- grad_count_T  in  CNT_W  shared reload threshold.
- ch_mask  in  N_CH  1 = channel disabled.
- lfsr_seed  in  16  LFSR seed, sampled at reset.
- stall_flag  out  N_CH  one-cycle pulse per channel fire.
- random_self_phase  out  N_CH  registered random phase bit per channel.
- any_stall  out  1  registered OR of this cycle's fires.
- stall_event_count  out  EVT_W  saturating total fires since reset.

Behaviour:
- Reset (sync, wins over every other input):
  - cnt[i] <= grad_count_T for all i.
  - stall_flag, random_self_phase, any_stall, stall_event_count <= 0.
  - lfsr <= lfsr_seed, or 16'hACE1 if the seed is 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances once per cycle while grad_counter_ena=1; holds otherwise.
  - Never reaches 0.
- Per channel i, evaluated each cycle when not in reset:
  - ena=0: cnt[i] holds; stall_flag[i] <= 0; random_self_phase[i] holds.
  - ena=1, ch_mask[i]=1: cnt[i] <= grad_count_T; no fire.
  - ena=1, grad_i != 0: cnt[i] <= grad_count_T; no fire.
  - ena=1, grad_i == 0, cnt[i] > 0: cnt[i] <= cnt[i]-1.
  - ena=1, grad_i == 0, cnt[i] == 0: fire.
    - stall_flag[i] <= 1.
    - random_self_phase[i] <= lfsr[i mod 16], using the pre-advance LFSR value.
    - cnt[i] <= grad_count_T.
  - Any non-firing cycle: stall_flag[i] <= 0.
  - random_self_phase[i] changes only on a fire of channel i.
- Latency: from a load of value T, a fire occurs on the (T+1)th consecutive qualifying cycle. stall_flag is visible on the next clock edge (1 cycle registered).
- T=0: every qualifying cycle fires, so stall_flag[i] stays high continuously.
- Threshold changes take effect only at the next reload. In-flight counts are not rescaled.
- any_stall <= OR of this cycle's fire vector (same timing as stall_flag).
- stall_event_count <= min(count + popcount(fires), 2^EVT_W - 1). Simultaneous fires from several channels are all counted in one cycle.
- Gradients are compared against all-zero over the full GRAD_W; no sign interpretation.
- No arithmetic underflow: decrement happens only when cnt > 0.

Test Plan:
- Reset with seed 0, T=3, one channel grad=0, ena=1 → stall_flag pulses on cycle 5 after reset release, then every 4 cycles; stall_event_count increments by 1 per pulse; LFSR starts at 16'hACE1.
- T=3, channel 2 grad=0 for 3 cycles then grad=4'h1 → no fire, cnt[2] reloads to 3; the next zero run needs a fresh 4 cycles.
- All 8 channels grad=0, T=1, ena=1 → all stall_flag bits high together every 2 cycles; stall_event_count +8 per fire cycle; random_self_phase[i] equals lfsr[i] from the fire cycle.
- T=2, toggle ena low for 5 cycles mid-count → counters and LFSR hold; the fire is delayed by exactly 5 cycles; random_self_phase unchanged.
- ch_mask=8'h01, T=0, all grads=0 → channel 0 never fires; channels 1..7 fire every cycle; with EVT_W=4, stall_event_count saturates at 15.
- Reset asserted concurrently with a fire condition → no stall_flag; all outputs 0 next cycle; cnt = T.
